// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard (device-to-host) frame receiver and key event
// encoder. Produces an 11-bit toggle-strobe key word {toggle, pressed, ext, code}.
// Optional feature macro: PS2_KEY_TYPEMATIC_FILTER_EN (suppresses auto-repeat makes).
module ps2_key_decoder #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int            TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    FILT_LAST = 4'(FILT_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // Input conditioning
    logic [1:0]    r_clk_sync, r_dat_sync;
    logic [3:0]    r_clk_cnt, r_dat_cnt;
    logic          r_clk_filt, r_dat_filt, r_clk_filt_d;
    logic          w_fall;

    // Frame FSM
    state_t        r_state, w_state_next;
    logic [2:0]    r_bitcnt, w_bitcnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_parity, w_parity_next;
    logic          w_byte_ok, w_stop_err, w_timeout;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_valid, r_frame_err;

    // Byte handler
    logic          r_ext, r_brk;
    logic [2:0]    r_skip;
    logic [10:0]   r_key;
    logic          w_is_noise, w_is_prefix, w_take, w_suppress, w_emit;

    // Two-flop synchronizers; idle PS/2 lines are high so they reset to 1
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk_in};
            r_dat_sync <= {r_dat_sync[0], ps2_data_in};
        end
    end

    // Saturating filters: level only follows after FILT_LEN consecutive differing samples
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_cnt    <= 4'd0;
            r_dat_cnt    <= 4'd0;
            r_clk_filt   <= 1'b1;
            r_dat_filt   <= 1'b1;
            r_clk_filt_d <= 1'b1;
        end else begin
            r_clk_filt_d <= r_clk_filt;
            if (r_clk_sync[1] == r_clk_filt) begin
                r_clk_cnt <= 4'd0;
            end else if (r_clk_cnt == FILT_LAST) begin
                r_clk_filt <= r_clk_sync[1];
                r_clk_cnt  <= 4'd0;
            end else begin
                r_clk_cnt <= r_clk_cnt + 4'd1;
            end
            if (r_dat_sync[1] == r_dat_filt) begin
                r_dat_cnt <= 4'd0;
            end else if (r_dat_cnt == FILT_LAST) begin
                r_dat_filt <= r_dat_sync[1];
                r_dat_cnt  <= 4'd0;
            end else begin
                r_dat_cnt <= r_dat_cnt + 4'd1;
            end
        end
    end

    assign w_fall = r_clk_filt_d & ~r_clk_filt;

    // Frame FSM state register plus one-cycle result pulses
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= 3'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bitcnt     <= w_bitcnt_next;
            r_shift      <= w_shift_next;
            r_parity     <= w_parity_next;
            r_byte_valid <= w_byte_ok;
            r_frame_err  <= w_stop_err | w_timeout;
        end
    end

    // Frame FSM next state: advances only on a filtered clock fall; a fall beats a timeout
    always_comb begin
        w_state_next  = r_state;
        w_bitcnt_next = r_bitcnt;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_byte_ok     = 1'b0;
        w_stop_err    = 1'b0;
        w_timeout     = (r_state != S_IDLE) && (r_to_cnt == TO_LAST) && !w_fall;
        if (w_timeout) begin
            w_state_next = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_dat_filt) begin
                        w_state_next  = S_DATA;
                        w_bitcnt_next = 3'd0;
                    end
                end
                S_DATA: begin
                    w_shift_next  = {r_dat_filt, r_shift[7:1]};
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        w_state_next = S_PARITY;
                    end
                end
                S_PARITY: begin
                    w_parity_next = r_dat_filt;
                    w_state_next  = S_STOP;
                end
                default: begin
                    w_state_next = S_IDLE;
                    if (r_dat_filt && (^{r_shift, r_parity})) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_stop_err = 1'b1;
                    end
                end
            endcase
        end
    end

    // Inter-edge watchdog: cleared by every fall, counts mid-frame, saturates at the limit
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt <= '0;
        end else if (w_fall || (r_state == S_IDLE)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign w_is_noise  = (r_shift == 8'h00) || (r_shift == 8'hAA) || (r_shift == 8'hEE) ||
                         (r_shift == 8'hFA) || (r_shift == 8'hFE) || (r_shift == 8'hFF);
    assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hE1) || (r_shift == 8'hF0);
    // A byte that completes a key event (possibly then filtered out as a repeat)
    assign w_take      = r_byte_valid && (r_skip == 3'd0) && !w_is_prefix &&
                         !(w_is_noise && !r_ext && !r_brk);
    assign w_emit      = w_take && !w_suppress;

`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    logic [9:0] r_last_key;

    // Remember the last emitted event so held-key repeats can be dropped
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_last_key <= 10'd0;
        end else if (w_emit) begin
            r_last_key <= {~r_brk, r_ext, r_shift};
        end
    end

    assign w_suppress = !r_brk && (r_last_key == {1'b1, r_ext, r_shift});
`else
    assign w_suppress = 1'b0;
`endif

    // Prefix tracking: E0/F0 flags, Pause-sequence swallowing, error cleanup
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
        end else if (w_stop_err) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_skip <= 3'd0;
        end else if (w_timeout) begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
        end else if (r_byte_valid) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_shift == 8'hE1) begin
                r_skip <= 3'd7;
            end else if (r_shift == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_shift == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (w_take) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    // Output key word: bit 10 flips once per emitted event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key <= 11'd0;
        end else if (w_emit) begin
            r_key <= {~r_key[10], ~r_brk, r_ext, r_shift};
        end
    end

    assign ps2_key   = r_key;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: randomized PS/2 frame stimulus with a byte-level reference
// model feeding a scoreboard queue; a monitor compares DUT key events and errors.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int FILT = 4;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic        clk_sys     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        ps2_clk_in  = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    ps2_key_decoder #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_key    (ps2_key),
        .frame_err  (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic       is_err;
        logic [9:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;
    logic prev_tog = 1'b0;

    // Reference model state, at the level of whole received bytes
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;
    int         m_skip = 0;
    logic [9:0] m_last = 10'd0;

    task automatic model_byte(input logic [7:0] b);
        logic [9:0] k;
        bit         sup;
        if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b == 8'hE1) begin
            m_skip = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_ext && !m_brk &&
                     (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                      b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
            // status code, no event
        end else begin
            k   = {~m_brk, m_ext, b};
            sup = 1'b0;
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
            sup = k[9] && (k == m_last);
`endif
            if (!sup) begin
                exp_q.push_back({1'b0, k});
                m_last = k;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err(input bit is_timeout);
        exp_q.push_back({1'b1, 10'd0});
        m_ext = 1'b0;
        m_brk = 1'b0;
        if (!is_timeout) m_skip = 0;
    endtask

    task automatic drive_bit(input logic v);
        ps2_data_in = v;
        repeat (HALF) @(posedge clk_sys);
        ps2_clk_in = 1'b0;
        repeat (HALF) @(posedge clk_sys);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~(^b)) ^ bad_par;
        if (bad_par || bad_stop) model_err(1'b0);
        else model_byte(b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(par);
        drive_bit(~bad_stop);
        ps2_data_in = 1'b1;
        repeat (HALF) @(posedge clk_sys);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0);
    endtask

    task automatic check_key(input string name, input logic [10:0] want);
        @(negedge clk_sys);
        checks++;
        if (ps2_key === want) passes++;
        else $display("FAIL %s: ps2_key=%h expected %h", name, ps2_key, want);
    endtask

    // Scoreboard monitor: every error pulse or bit-10 flip consumes one expectation
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (frame_err) begin
                checks++;
                if (exp_q.size() != 0 && exp_q[0].is_err) begin
                    passes++;
                    void'(exp_q.pop_front());
                    $display("frame_err pulse at %0t", $time);
                end else begin
                    $display("FAIL frame_err: unexpected pulse at %0t, pending=%0d", $time, exp_q.size());
                end
            end
            if (ps2_key[10] !== prev_tog) begin
                prev_tog = ps2_key[10];
                checks++;
                if (exp_q.size() != 0 && !exp_q[0].is_err && exp_q[0].key === ps2_key[9:0]) begin
                    passes++;
                    $display("key event %h at %0t", ps2_key, $time);
                    void'(exp_q.pop_front());
                end else begin
                    $display("FAIL key_event: got %h expected %s %h", ps2_key[9:0],
                             (exp_q.size() == 0) ? "none" : (exp_q[0].is_err ? "err" : "key"),
                             (exp_q.size() == 0) ? 10'd0 : exp_q[0].key);
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] specials [6];
        bit         bad_rst;
        int         r, w;
        logic [7:0] b;
        specials[0] = 8'h00; specials[1] = 8'hAA; specials[2] = 8'hEE;
        specials[3] = 8'hFA; specials[4] = 8'hFE; specials[5] = 8'hFF;

        repeat (5) @(posedge clk_sys);
        reset_n = 1'b1;

        // Idle after reset: outputs stay at zero
        bad_rst = 1'b0;
        repeat (10000) begin
            @(negedge clk_sys);
            if (ps2_key !== 11'h000 || frame_err !== 1'b0) bad_rst = 1'b1;
        end
        checks++;
        if (!bad_rst) passes++;
        else $display("FAIL reset_idle: ps2_key=%h frame_err=%b expected 000/0", ps2_key, frame_err);
        mon_en = 1'b1;

        // Directed sequences
        send_good(8'h1C);
        check_key("make_A", 11'h61C);
        send_good(8'hF0); send_good(8'h1C);
        check_key("break_A", 11'h01C);
        send_good(8'hE0); send_good(8'h75);
        check_key("ext_make", 11'h775);
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        check_key("ext_break", 11'h175);

        send_frame(8'h29, 1'b1, 1'b0);
        check_key("after_bad_parity", 11'h175);
        send_good(8'h29);
        check_key("good_29", 11'h629);

        // Timeout: start bit plus four data bits, then clock stops
        model_err(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        ps2_data_in = 1'b1;
        repeat (TO + 100) @(posedge clk_sys);
        send_good(8'h16);
        check_key("after_timeout", 11'h216);

        // Pause sequence swallowed, then a normal key
        send_good(8'hE1); send_good(8'h14); send_good(8'h77); send_good(8'hE1);
        send_good(8'hF0); send_good(8'h14); send_good(8'hF0); send_good(8'h77);
        send_good(8'h05);
        check_key("after_pause", 11'h605);
        send_good(8'hF0); send_good(8'h05);

        // Typematic repeats then release
        send_good(8'h05); send_good(8'h05); send_good(8'h05);
        send_good(8'hF0); send_good(8'h05);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       b = 8'hE0;
            else if (r < 16) b = 8'hF0;
            else if (r < 18) b = 8'hE1;
            else if (r < 24) b = specials[$urandom_range(0, 5)];
            else             b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            send_frame(b, r < 6, (r >= 6) && (r < 9));
        end

        // Drain the scoreboard
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk_sys);
            w++;
        end
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
